// File: rtl/stage_sequencer_pkg.sv
// Shared constants and types for the instruction stage sequencer.
package stage_sequencer_pkg;

  // Fixed stage numbers; Execute/Memory/WriteBack positions depend on NUM_STAGES.
  localparam int STG_IDLE   = 0;
  localparam int STG_FETCH  = 1;
  localparam int STG_DECODE = 2;

  // Memory interface command encodings driven on MEM_r_w_z_z.
  localparam logic [1:0] MEM_READ  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_HIZ   = 2'b11;

  // Per-instruction memory operation supplied by the decoder.
  typedef enum logic [1:0] {
    MOP_NONE = 2'b00,
    MOP_RD   = 2'b01,
    MOP_WR   = 2'b10,
    MOP_RDWB = 2'b11
  } mem_op_e;

  // Role of the current stage number; PH_BAD covers values above NUM_STAGES.
  typedef enum logic [2:0] {
    PH_IDLE,
    PH_FETCH,
    PH_DECODE,
    PH_EXEC,
    PH_MEM,
    PH_WB,
    PH_BAD
  } phase_e;

  // Memory command issued during the Memory stage for a given operation.
  function automatic logic [1:0] mem_code(input mem_op_e op);
    case (op)
      MOP_RD, MOP_RDWB: mem_code = MEM_READ;
      MOP_WR:           mem_code = MEM_WRITE;
      default:          mem_code = MEM_HIZ;
    endcase
  endfunction

endpackage

// File: rtl/stage_wait_timer.sv
// Counts cycles spent waiting for Mem_Ready and raises a sticky fault on timeout.
module stage_wait_timer #(
  parameter int MEM_TIMEOUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_active,   // in a wait stage and not stalled this cycle
  input  logic mem_ready,
  input  logic stage_change,  // stage register changes at the next edge
  output logic timeout,       // give up waiting this cycle (no Mem_Ready)
  output logic mem_fault
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  // Ready wins over timeout, so a late Mem_Ready never sets the fault.
  assign timeout = wait_active && !mem_ready && (count_q == CNT_LAST);

  // Wait counter: restarts on every stage change, holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (stage_change) begin
      count_q <= '0;
    end else if (wait_active) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_fault <= 1'b0;
    end else if (timeout) begin
      mem_fault <= 1'b1;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Stage counter and register-enable decoder for the multi-cycle CPU.
// Mem_Ready handshake: in a wait stage (Fetch, or Memory with Mem_Op != none)
// the access completes on any non-stalled cycle where Mem_Ready=1; the stage
// then advances at the next edge. Mem_Ready outside a wait stage or during
// Stall is ignored. If no Mem_Ready arrives within MEM_TIMEOUT cycles the stage
// advances anyway and Mem_Fault is set.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int STAGE_W     = 3,
  parameter int MEM_TIMEOUT = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Stall,
  input  logic               NOP_Flag,
  input  logic [1:0]         Mem_Op,
  input  logic               Mem_Ready,
  input  logic               Branch_Taken,
  input  logic               MA_Select_Mem,
  input  logic               PC_Select_WB,
  input  logic               INC_Select_WB,
  output logic [STAGE_W-1:0] Stage,
  output logic               IR_Enable,
  output logic               PC_Enable,
  output logic               RA_Enable,
  output logic               RB_Enable,
  output logic               RZ_Enable,
  output logic               CCR_Enable,
  output logic               RM_Enable,
  output logic               RY_Enable,
  output logic               MA_Select,
  output logic [1:0]         MEM_r_w_z_z,
  output logic               RF_WRITE,
  output logic               PC_Select,
  output logic               INC_Select,
  output logic               Instr_Done,
  output logic               Mem_Fault
);

  localparam logic [STAGE_W-1:0] S_IDLE    = STAGE_W'(STG_IDLE);
  localparam logic [STAGE_W-1:0] S_FETCH   = STAGE_W'(STG_FETCH);
  localparam logic [STAGE_W-1:0] S_DECODE  = STAGE_W'(STG_DECODE);
  localparam logic [STAGE_W-1:0] S_LAST_EX = STAGE_W'(NUM_STAGES - 2);
  localparam logic [STAGE_W-1:0] S_MEM     = STAGE_W'(NUM_STAGES - 1);
  localparam logic [STAGE_W-1:0] S_WB      = STAGE_W'(NUM_STAGES);

  logic [STAGE_W-1:0] stage_q;
  logic [STAGE_W-1:0] stage_d;
  phase_e             phase;
  mem_op_e            mem_op;
  logic               wait_active;
  logic               wait_done;
  logic               timeout;

  assign mem_op = mem_op_e'(Mem_Op);
  assign Stage  = stage_q;

  // Classify the current stage number into its pipeline role.
  always_comb begin
    phase = PH_BAD;
    if (stage_q == S_IDLE)          phase = PH_IDLE;
    else if (stage_q == S_FETCH)    phase = PH_FETCH;
    else if (stage_q == S_DECODE)   phase = PH_DECODE;
    else if (stage_q <= S_LAST_EX)  phase = PH_EXEC;
    else if (stage_q == S_MEM)      phase = PH_MEM;
    else if (stage_q == S_WB)       phase = PH_WB;
  end

  assign wait_active = !Stall &&
                       ((phase == PH_FETCH) || ((phase == PH_MEM) && (mem_op != MOP_NONE)));
  assign wait_done   = wait_active && (Mem_Ready || timeout);

  stage_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk          (Clock),
    .reset        (Reset),
    .wait_active  (wait_active),
    .mem_ready    (Mem_Ready),
    .stage_change (stage_d != stage_q),
    .timeout      (timeout),
    .mem_fault    (Mem_Fault)
  );

  // Next stage and datapath control decode; Stall overrides at the end.
  always_comb begin
    stage_d     = stage_q;
    IR_Enable   = 1'b0;
    PC_Enable   = 1'b0;
    RA_Enable   = 1'b0;
    RB_Enable   = 1'b0;
    RZ_Enable   = 1'b0;
    CCR_Enable  = 1'b0;
    RM_Enable   = 1'b0;
    RY_Enable   = 1'b0;
    MA_Select   = 1'b1;
    MEM_r_w_z_z = MEM_HIZ;
    RF_WRITE    = 1'b0;
    PC_Select   = 1'b1;
    INC_Select  = 1'b0;
    Instr_Done  = 1'b0;
    case (phase)
      PH_IDLE: begin
        if (Run) stage_d = S_FETCH;
      end
      PH_FETCH: begin
        IR_Enable   = 1'b1;
        MEM_r_w_z_z = MEM_READ;
        if (wait_done) begin
          PC_Enable = 1'b1;
          stage_d   = S_DECODE;
        end
      end
      PH_DECODE: begin
        RA_Enable = 1'b1;
        RB_Enable = 1'b1;
        if (NOP_Flag) begin
          Instr_Done = 1'b1;
          stage_d    = Run ? S_FETCH : S_IDLE;
        end else begin
          stage_d = S_DECODE + 1'b1;
        end
      end
      PH_EXEC: begin
        if (stage_q == S_LAST_EX) begin
          RZ_Enable  = 1'b1;
          RM_Enable  = 1'b1;
          CCR_Enable = 1'b1;
        end
        stage_d = stage_q + 1'b1;
      end
      PH_MEM: begin
        MA_Select   = MA_Select_Mem;
        MEM_r_w_z_z = mem_code(mem_op);
        if ((mem_op == MOP_NONE) || wait_done) begin
          RY_Enable = 1'b1;
          stage_d   = S_WB;
        end
      end
      PH_WB: begin
        MA_Select   = MA_Select_Mem;
        PC_Select   = PC_Select_WB;
        INC_Select  = INC_Select_WB;
        PC_Enable   = Branch_Taken;
        RF_WRITE    = (mem_op == MOP_RDWB);
        MEM_r_w_z_z = Mem_Op[0] ? MEM_READ : MEM_HIZ;
        Instr_Done  = 1'b1;
        stage_d     = Run ? S_FETCH : S_IDLE;
      end
      default: begin
        stage_d = S_IDLE;
      end
    endcase
    if (Stall) begin
      stage_d     = stage_q;
      IR_Enable   = 1'b0;
      PC_Enable   = 1'b0;
      RA_Enable   = 1'b0;
      RB_Enable   = 1'b0;
      RZ_Enable   = 1'b0;
      CCR_Enable  = 1'b0;
      RM_Enable   = 1'b0;
      RY_Enable   = 1'b0;
      RF_WRITE    = 1'b0;
      Instr_Done  = 1'b0;
      MEM_r_w_z_z = MEM_HIZ;
    end
  end

  // Stage register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stage_q <= S_IDLE;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a 5-stage and a 6-stage instance share stimulus,
// each with its own reset, so one can run while the other is held idle.
module tb_stage_sequencer;

  localparam int TO = 4;
  localparam int OW = 19;

  logic Clock = 1'b0;
  logic Reset_5, Reset_6;
  logic Run, Stall, NOP_Flag, Mem_Ready, Branch_Taken;
  logic MA_Select_Mem, PC_Select_WB, INC_Select_WB;
  logic [1:0] Mem_Op;

  logic [2:0] stage5, stage6;
  logic [1:0] mem5, mem6;
  logic ir5, pce5, ra5, rb5, rz5, ccr5, rm5, ry5, ma5, rf5, pcs5, incs5, done5, flt5;
  logic ir6, pce6, ra6, rb6, rz6, ccr6, rm6, ry6, ma6, rf6, pcs6, incs6, done6, flt6;
  logic [OW-1:0] got5, got6;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  int  m_stg[2];
  int  m_cnt[2];
  bit  m_flt[2];

  // Clock and watchdog
  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  stage_sequencer #(.NUM_STAGES(5), .STAGE_W(3), .MEM_TIMEOUT(TO)) dut5 (
    .Clock(Clock), .Reset(Reset_5), .Run(Run), .Stall(Stall), .NOP_Flag(NOP_Flag),
    .Mem_Op(Mem_Op), .Mem_Ready(Mem_Ready), .Branch_Taken(Branch_Taken),
    .MA_Select_Mem(MA_Select_Mem), .PC_Select_WB(PC_Select_WB), .INC_Select_WB(INC_Select_WB),
    .Stage(stage5), .IR_Enable(ir5), .PC_Enable(pce5), .RA_Enable(ra5), .RB_Enable(rb5),
    .RZ_Enable(rz5), .CCR_Enable(ccr5), .RM_Enable(rm5), .RY_Enable(ry5), .MA_Select(ma5),
    .MEM_r_w_z_z(mem5), .RF_WRITE(rf5), .PC_Select(pcs5), .INC_Select(incs5),
    .Instr_Done(done5), .Mem_Fault(flt5));

  stage_sequencer #(.NUM_STAGES(6), .STAGE_W(3), .MEM_TIMEOUT(TO)) dut6 (
    .Clock(Clock), .Reset(Reset_6), .Run(Run), .Stall(Stall), .NOP_Flag(NOP_Flag),
    .Mem_Op(Mem_Op), .Mem_Ready(Mem_Ready), .Branch_Taken(Branch_Taken),
    .MA_Select_Mem(MA_Select_Mem), .PC_Select_WB(PC_Select_WB), .INC_Select_WB(INC_Select_WB),
    .Stage(stage6), .IR_Enable(ir6), .PC_Enable(pce6), .RA_Enable(ra6), .RB_Enable(rb6),
    .RZ_Enable(rz6), .CCR_Enable(ccr6), .RM_Enable(rm6), .RY_Enable(ry6), .MA_Select(ma6),
    .MEM_r_w_z_z(mem6), .RF_WRITE(rf6), .PC_Select(pcs6), .INC_Select(incs6),
    .Instr_Done(done6), .Mem_Fault(flt6));

  assign got5 = {stage5, ir5, pce5, ra5, rb5, rz5, ccr5, rm5, ry5, ma5, mem5, rf5, pcs5, incs5, done5, flt5};
  assign got6 = {stage6, ir6, pce6, ra6, rb6, rz6, ccr6, rm6, ry6, ma6, mem6, rf6, pcs6, incs6, done6, flt6};

  // Reference model: for an n-stage machine in stage stg with cnt cycles already
  // waited, give the required outputs and the state after the next edge.
  task automatic model_eval(input int n, input int stg, input int cnt, input bit flt,
                            output logic [OW-1:0] o, output int nstg, output int ncnt,
                            output bit nflt);
    bit ir, pce, ra, rb, rz, ccr, rm, ry, ma, rf, pcs, incs, done;
    logic [1:0] mem;
    bit waits, expired, ready;
    ir = 0; pce = 0; ra = 0; rb = 0; rz = 0; ccr = 0; rm = 0; ry = 0;
    rf = 0; incs = 0; done = 0; ma = 1; pcs = 1; mem = 2'b11;
    nstg = stg;
    waits   = (stg == 1) || (stg == n - 1 && Mem_Op != 2'b00);
    expired = waits && !Stall && !Mem_Ready && (cnt == TO - 1);
    ready   = !Stall && (Mem_Ready || expired);
    if (stg == 0) begin
      if (Run) nstg = 1;
    end else if (stg == 1) begin
      ir = 1; mem = 2'b00;
      if (ready) begin pce = 1; nstg = 2; end
    end else if (stg == 2) begin
      ra = 1; rb = 1;
      if (NOP_Flag) begin done = 1; nstg = Run ? 1 : 0; end
      else nstg = 3;
    end else if (stg <= n - 2) begin
      if (stg == n - 2) begin rz = 1; rm = 1; ccr = 1; end
      nstg = stg + 1;
    end else if (stg == n - 1) begin
      ma = MA_Select_Mem;
      case (Mem_Op)
        2'b00: mem = 2'b11;
        2'b10: mem = 2'b01;
        default: mem = 2'b00;
      endcase
      if (Mem_Op == 2'b00 || ready) begin ry = 1; nstg = n; end
    end else if (stg == n) begin
      ma = MA_Select_Mem; pcs = PC_Select_WB; incs = INC_Select_WB;
      pce = Branch_Taken; rf = (Mem_Op == 2'b11);
      mem = Mem_Op[0] ? 2'b00 : 2'b11;
      done = 1; nstg = Run ? 1 : 0;
    end else begin
      nstg = 0;
    end
    if (Stall) begin
      ir = 0; pce = 0; ra = 0; rb = 0; rz = 0; ccr = 0; rm = 0; ry = 0;
      rf = 0; done = 0; mem = 2'b11; nstg = stg;
    end
    nflt = flt | expired;
    if (nstg != stg) ncnt = 0;
    else if (waits && !Stall) ncnt = cnt + 1;
    else ncnt = cnt;
    o = {3'(stg), ir, pce, ra, rb, rz, ccr, rm, ry, ma, mem, rf, pcs, incs, done, flt};
  endtask

  // Scoreboard compare: both instances against the model every cycle.
  always @(negedge Clock) begin
    logic [OW-1:0] e;
    int a, b;
    bit c;
    model_eval(5, m_stg[0], m_cnt[0], m_flt[0], e, a, b, c);
    checks++;
    if (got5 !== e) begin
      errors++;
      $display("FAIL model_n5 t=%0t got=%h exp=%h", $time, got5, e);
    end
    model_eval(6, m_stg[1], m_cnt[1], m_flt[1], e, a, b, c);
    checks++;
    if (got6 !== e) begin
      errors++;
      $display("FAIL model_n6 t=%0t got=%h exp=%h", $time, got6, e);
    end
  end

  // Model state advance on the active edge.
  always @(posedge Clock) begin
    logic [OW-1:0] e;
    int a, b;
    bit c;
    model_eval(5, m_stg[0], m_cnt[0], m_flt[0], e, a, b, c);
    if (Reset_5) begin m_stg[0] = 0; m_cnt[0] = 0; m_flt[0] = 0; end
    else begin m_stg[0] = a; m_cnt[0] = b; m_flt[0] = c; end
    model_eval(6, m_stg[1], m_cnt[1], m_flt[1], e, a, b, c);
    if (Reset_6) begin m_stg[1] = 0; m_cnt[1] = 0; m_flt[1] = 0; end
    else begin m_stg[1] = a; m_cnt[1] = b; m_flt[1] = c; end
  end

  // Driver helpers
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Directed (Stall, Mem_Ready) pattern for the mixed-traffic phase.
  localparam logic [23:0] STALL_PAT = 24'b000011000001100000110000;
  localparam logic [23:0] READY_PAT = 24'b010000010000000100000001;

  initial begin
    logic [2:0] e;
    logic [23:0] sp, rp;
    m_stg = '{0, 0}; m_cnt = '{0, 0}; m_flt = '{0, 0};
    Reset_5 = 1; Reset_6 = 1; Run = 0; Stall = 0; NOP_Flag = 0; Mem_Op = 2'b00;
    Mem_Ready = 0; Branch_Taken = 0; MA_Select_Mem = 0; PC_Select_WB = 1; INC_Select_WB = 0;
    tick(); tick();
    @(negedge Clock);
    check("reset_stage5", stage5, 0);
    check("reset_fault5", flt5, 0);
    check("reset_stage6", stage6, 0);
    tick();

    // 5-stage load with register write-back, back to back.
    Reset_5 = 0; Run = 1; Mem_Ready = 1; Mem_Op = 2'b11;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{0, 1, 2, 3, 4, 5, 1, 2, 3, 4, 5};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge Clock);
      check("seq5_stage", stage5, e);
      check("seq5_rf_write", rf5, (e == 3'd5));
      check("seq5_done", done5, (e == 3'd5));
      tick();
    end

    // 6-stage store: two Execute stages, write command in Memory.
    Reset_5 = 1; Reset_6 = 0; Mem_Op = 2'b10;
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 1};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge Clock);
      check("seq6_stage", stage6, e);
      check("seq6_rz", rz6, (e == 3'd4));
      check("seq6_mem", mem6, (e == 3'd1) ? 2'b00 : (e == 3'd5) ? 2'b01 : 2'b11);
      check("seq6_rf_write", rf6, 0);
      tick();
    end

    // NOP retires from Decode.
    Reset_6 = 1; Reset_5 = 0; Mem_Op = 2'b11; NOP_Flag = 1;
    exp_q = '{0, 1, 2, 1, 2, 1};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge Clock);
      check("nop_stage", stage5, e);
      check("nop_done", done5, (e == 3'd2));
      check("nop_rz", rz5, 0);
      check("nop_rf_write", rf5, 0);
      tick();
    end
    NOP_Flag = 0;

    // Memory read with no Mem_Ready: held TO cycles, then forced on.
    Reset_5 = 1;
    tick();
    Reset_5 = 0; Mem_Op = 2'b01; Mem_Ready = 1;
    exp_q = '{0, 1, 2, 3};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge Clock);
      check("to_lead_stage", stage5, e);
      tick();
    end
    Mem_Ready = 0; Run = 0;
    exp_q = '{4, 4, 4, 4, 5, 0, 0};
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front();
      @(negedge Clock);
      check("to_stage", stage5, e);
      check("to_fault", flt5, (k >= 4));
      tick();
    end
    Reset_5 = 1;
    tick();
    @(negedge Clock);
    check("to_fault_cleared", flt5, 0);
    tick();

    // Stall for three cycles in Fetch with Mem_Ready high.
    Reset_5 = 0; Run = 1; Mem_Ready = 1; Mem_Op = 2'b11;
    @(negedge Clock);
    check("stall_pre_stage", stage5, 0);
    tick();
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check("stall_stage", stage5, 1);
      check("stall_ir", ir5, 0);
      check("stall_mem", mem5, 2'b11);
      check("stall_pc_en", pce5, 0);
      tick();
    end
    Stall = 0;
    @(negedge Clock);
    check("stall_end_stage", stage5, 1);
    check("stall_end_ir", ir5, 1);
    check("stall_end_mem", mem5, 2'b00);
    check("stall_end_pc_en", pce5, 1);
    tick();
    @(negedge Clock);
    check("stall_resume_stage", stage5, 2);

    // Taken branch in WriteBack, then reset landing on a WriteBack.
    Branch_Taken = 1; PC_Select_WB = 0; INC_Select_WB = 1; MA_Select_Mem = 1;
    tick(); tick(); tick();
    @(negedge Clock);
    check("br_stage", stage5, 5);
    check("br_pc_en", pce5, 1);
    check("br_pc_sel", pcs5, 0);
    check("br_inc_sel", incs5, 1);
    check("br_rf_write", rf5, 1);
    tick(); tick(); tick(); tick(); tick();
    Reset_5 = 1;
    tick();
    @(negedge Clock);
    check("rst_wb_stage", stage5, 0);
    check("rst_wb_pc_en", pce5, 0);
    tick();

    // 6-stage Fetch: Mem_Ready arrives on the last permitted wait cycle.
    Reset_6 = 0; Branch_Taken = 0; Mem_Ready = 0; Mem_Op = 2'b00;
    tick(); tick(); tick(); tick();
    Mem_Ready = 1;
    @(negedge Clock);
    check("late_rdy_stage", stage6, 1);
    check("late_rdy_pc_en", pce6, 1);
    tick();
    @(negedge Clock);
    check("late_rdy_next", stage6, 2);
    check("late_rdy_fault", flt6, 0);
    tick();

    // Mixed traffic on the 6-stage instance: stalls and sparse Mem_Ready.
    Mem_Op = 2'b01;
    sp = STALL_PAT;
    rp = READY_PAT;
    for (int k = 0; k < 24; k++) begin
      Stall = sp[k];
      Mem_Ready = rp[k];
      MA_Select_Mem = k[0];
      tick();
    end
    Stall = 0;
    Mem_Ready = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
